// File: rtl/bcond_resolve_if.sv
// rtl/bcond_resolve_if.sv - decode/EX/flag-register side of the B.cond resolution stage
interface bcond_resolve_if #(
  parameter int ADDR_W = 64
);
  logic              id_bcond_valid;
  logic [3:0]        id_cond;
  logic [ADDR_W-1:0] id_target;
  logic              id_set_flags;
  logic              ex_flag_valid;
  logic [3:0]        ex_flags;
  logic [3:0]        flag_q;
  logic              stall;
  logic              br_valid;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              err;

  modport master (
    output id_bcond_valid, id_cond, id_target, id_set_flags,
    output ex_flag_valid, ex_flags, flag_q,
    input  stall, br_valid, br_taken, br_target, err
  );

  modport slave (
    input  id_bcond_valid, id_cond, id_target, id_set_flags,
    input  ex_flag_valid, ex_flags, flag_q,
    output stall, br_valid, br_taken, br_target, err
  );
endinterface

// File: rtl/bcond_resolve.sv
// rtl/bcond_resolve.sv - B.cond resolution: holds a branch until in-flight flag setters drain, then evaluates it
// Optional BCOND_FWD_EN: resolve in WAIT directly from ex_flags on the final flag write (one cycle earlier).
module bcond_resolve #(
  parameter int ADDR_W   = 64,
  parameter int MAX_PEND = 3
) (
  input  logic           clk,
  input  logic           reset,
  bcond_resolve_if.slave bus
);
  localparam int PW = $clog2(MAX_PEND + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE} state_t;

  state_t            state_q;
  logic [PW-1:0]     pend_q;
  logic [PW-1:0]     pend_d;
  logic [3:0]        cond_q;
  logic [ADDR_W-1:0] target_q;
  logic              br_valid_q;
  logic              br_taken_q;
  logic [ADDR_W-1:0] br_target_q;
  logic              err_q;

  logic stall;
  logic br_accept;
  logic set_accept;
  logic flag_dec;
  logic underflow;
  logic proto_err;

  // Low bit of the condition code inverts the base test, except for the 111x always-taken pair.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic z, n, v, cy, base;
    {z, n, v, cy} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'b111) ? 1'b1 : (base ^ c[0]);
  endfunction

  assign stall      = (state_q != S_IDLE) || (pend_q == PW'(MAX_PEND));
  assign br_accept  = bus.id_bcond_valid && !stall;
  assign set_accept = bus.id_set_flags && !stall && !bus.id_bcond_valid;
  assign underflow  = bus.ex_flag_valid && (pend_q == '0);
  assign flag_dec   = bus.ex_flag_valid && !underflow;
  assign proto_err  = underflow
                   || (stall && (bus.id_set_flags || bus.id_bcond_valid))
                   || (bus.id_set_flags && br_accept);

  always_comb begin
    pend_d = pend_q;
    if (set_accept && !flag_dec) begin
      pend_d = pend_q + 1'b1;
    end else if (!set_accept && flag_dec) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      cond_q      <= '0;
      target_q    <= '0;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      err_q       <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      br_valid_q <= 1'b0;
      if (proto_err) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (br_accept) begin
            cond_q   <= bus.id_cond;
            target_q <= bus.id_target;
            state_q  <= (pend_d == '0) ? S_RESOLVE : S_WAIT;
          end
        end
        S_WAIT: begin
`ifdef BCOND_FWD_EN
          // Final flag write is in flight now; use the ALU flags before they land in flag_q.
          if (bus.ex_flag_valid && (pend_q == PW'(1))) begin
            br_valid_q  <= 1'b1;
            br_taken_q  <= cond_eval(cond_q, bus.ex_flags);
            br_target_q <= target_q;
            state_q     <= S_IDLE;
          end else if (pend_d == '0) begin
            state_q <= S_RESOLVE;
          end
`else
          if (pend_d == '0) begin
            state_q <= S_RESOLVE;
          end
`endif
        end
        S_RESOLVE: begin
          br_valid_q  <= 1'b1;
          br_taken_q  <= cond_eval(cond_q, bus.flag_q);
          br_target_q <= target_q;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stall     = stall;
  assign bus.br_valid  = br_valid_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_target = br_target_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bcond_resolve.sv
// tb/tb_bcond_resolve.sv - self-checking bench for bcond_resolve (honours BCOND_FWD_EN when defined)
module tb_bcond_resolve;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  bcond_resolve_if #(.ADDR_W(64)) ifc ();

  bcond_resolve #(.ADDR_W(64), .MAX_PEND(3)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag register model sitting upstream of the DUT, with a bench-only preload port.
  logic [3:0] fr;
  logic       fr_load;
  logic [3:0] fr_val;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 fr <= 4'b0;
    else if (ifc.ex_flag_valid) fr <= ifc.ex_flags;
    else if (fr_load)           fr <= fr_val;
  end
  assign ifc.flag_q = fr;

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    bit z, n, v, cy;
    z = f[3]; n = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle_branch(input logic [3:0] cond, input logic [3:0] flags, input logic [63:0] tgt);
    fr_load = 1'b1; fr_val = flags;
    step();
    fr_load = 1'b0;
    ifc.id_bcond_valid = 1'b1; ifc.id_cond = cond; ifc.id_target = tgt;
    chk("idle_stall", ifc.stall, 0);
    step();
    ifc.id_bcond_valid = 1'b0;
    chk("c1_stall", ifc.stall, 1);
    chk("c1_nopulse", ifc.br_valid, 0);
    step();
    chk("c2_pulse", ifc.br_valid, 1);
    chk("c2_taken", ifc.br_taken, cond_ref(cond, flags));
    chk("c2_target", ifc.br_target, tgt);
    chk("c2_stall", ifc.stall, 0);
    step();
    chk("c3_nopulse", ifc.br_valid, 0);
  endtask

  task automatic run_wait_branch(input int n_set, input logic [3:0] cond, input logic [63:0] tgt,
                                 input int gap, input logic [3:0] last_flags);
    logic [3:0] fl;
    for (int i = 0; i < n_set; i++) begin
      ifc.id_set_flags = 1'b1;
      step();
    end
    ifc.id_set_flags = 1'b0;
    ifc.id_bcond_valid = 1'b1; ifc.id_cond = cond; ifc.id_target = tgt;
    step();
    ifc.id_bcond_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      chk("gap_stall", ifc.stall, 1);
      chk("gap_nopulse", ifc.br_valid, 0);
      step();
    end
    for (int i = 0; i < n_set; i++) begin
      fl = (i == n_set - 1) ? last_flags : 4'($urandom);
      chk("wait_stall", ifc.stall, 1);
      chk("wait_nopulse", ifc.br_valid, 0);
      ifc.ex_flag_valid = 1'b1; ifc.ex_flags = fl;
      step();
    end
    ifc.ex_flag_valid = 1'b0;
`ifndef BCOND_FWD_EN
    chk("k1_nopulse", ifc.br_valid, 0);
    step();
`endif
    chk("w_pulse", ifc.br_valid, 1);
    chk("w_taken", ifc.br_taken, cond_ref(cond, last_flags));
    chk("w_target", ifc.br_target, tgt);
    chk("w_stall", ifc.stall, 0);
    step();
    chk("w_pulse_once", ifc.br_valid, 0);
  endtask

  initial begin
    logic [3:0]  c;
    logic [3:0]  f;
    logic [63:0] t;
    tests = 0; fails = 0;
    fr_load = 1'b0; fr_val = 4'b0;
    ifc.id_bcond_valid = 1'b0; ifc.id_cond = 4'b0; ifc.id_target = 64'b0;
    ifc.id_set_flags = 1'b0; ifc.ex_flag_valid = 1'b0; ifc.ex_flags = 4'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_br_valid", ifc.br_valid, 0);
    chk("rst_stall", ifc.stall, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_target", ifc.br_target, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // EQ with Z set at pend=0
    run_idle_branch(4'b0000, 4'b1000, 64'hDEAD_BEEF_0000_1234);
    // GE waiting on one flag setter; flags arrive two cycles after the branch
    run_wait_branch(1, 4'b1010, 64'h0000_0000_0040_0100, 1, 4'b0110);

    // Branch together with the final flag write while in IDLE
    ifc.id_set_flags = 1'b1;
    step();
    ifc.id_set_flags = 1'b0;
    ifc.id_bcond_valid = 1'b1; ifc.id_cond = 4'b0001; ifc.id_target = 64'h1111;
    ifc.ex_flag_valid = 1'b1; ifc.ex_flags = 4'b1000;
    step();
    ifc.id_bcond_valid = 1'b0; ifc.ex_flag_valid = 1'b0;
    chk("same_c1_stall", ifc.stall, 1);
    chk("same_c1_nopulse", ifc.br_valid, 0);
    step();
    chk("same_c2_pulse", ifc.br_valid, 1);
    chk("same_c2_taken", ifc.br_taken, 0);
    chk("same_c2_target", ifc.br_target, 64'h1111);
    step();

    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom);
      f = 4'($urandom);
      t = {32'($urandom), 32'($urandom)};
      run_wait_branch(int'($urandom_range(1, 2)), c, t, int'($urandom_range(0, 2)), f);
    end

    for (int ci = 0; ci < 16; ci++) begin
      for (int fi = 0; fi < 16; fi++) begin
        run_idle_branch(4'(ci), 4'(fi), {32'($urandom), 28'd0, 4'(fi)});
      end
    end

    // Counter saturation at MAX_PEND
    ifc.id_set_flags = 1'b1;
    step(); step();
    chk("pend2_stall", ifc.stall, 0);
    step();
    ifc.id_set_flags = 1'b0;
    chk("pend3_stall", ifc.stall, 1);
    ifc.ex_flag_valid = 1'b1; ifc.ex_flags = 4'b0;
    step();
    chk("pend2_unstall", ifc.stall, 0);
    step(); step();
    ifc.ex_flag_valid = 1'b0;
    chk("no_err_yet", ifc.err, 0);

    // Flag write with nothing in flight
    ifc.ex_flag_valid = 1'b1; ifc.ex_flags = 4'b0001;
    step();
    ifc.ex_flag_valid = 1'b0;
    chk("underflow_err", ifc.err, 1);
    chk("underflow_stall", ifc.stall, 0);
    step();
    chk("err_sticky", ifc.err, 1);
    run_idle_branch(4'b0010, 4'b0001, 64'h2222);
    chk("err_sticky2", ifc.err, 1);

    // Reset while a branch waits
    ifc.id_set_flags = 1'b1;
    step();
    ifc.id_set_flags = 1'b0;
    ifc.id_bcond_valid = 1'b1; ifc.id_cond = 4'b1110; ifc.id_target = 64'h3333;
    step();
    ifc.id_bcond_valid = 1'b0;
    chk("prereset_stall", ifc.stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", ifc.stall, 0);
    chk("mid_rst_err", ifc.err, 0);
    chk("mid_rst_taken", ifc.br_taken, 0);
    chk("mid_rst_target", ifc.br_target, 0);
    chk("mid_rst_valid", ifc.br_valid, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_nopulse", ifc.br_valid, 0);
    end
    chk("post_rst_stall", ifc.stall, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcond_resolve.md
# bcond_resolve

Conditional-branch resolution stage sitting directly downstream of the flag register in the pipelined CPU. Tracks how many flag-setting instructions (ADDS/SUBS) are in flight and holds a decoded B.cond until its flags are final. It then evaluates the LEGv8 condition code against those flags and emits a one-cycle resolved-branch pulse with the taken decision and target. Decode stalls while a branch is unresolved or the in-flight counter is full.

## Interface
Parameters:
- ADDR_W, 64, branch target width
- MAX_PEND, 3, maximum flag-setting instructions in flight between decode and EX

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- id_bcond_valid  in  1  decode presents a B.cond this cycle
- id_cond  in  4  condition code of the B.cond
- id_target  in  ADDR_W  computed branch target
- id_set_flags  in  1  decode issues a flag-setting instruction this cycle
- ex_flag_valid  in  1  ALU flags for the oldest in-flight flag-setter are valid this cycle; equals the flag register's enable
- ex_flags  in  4  ALU flags, ordered {zero, neg, overflow, carry_out}
- flag_q  in  4  flag register output, same ordering
- stall  out  1  decode must hold
- br_valid  out  1  registered one-cycle resolved-branch pulse
- br_taken  out  1  registered; meaningful only with br_valid
- br_target  out  ADDR_W  registered; copy of the held target
- err  out  1  sticky protocol error

## Operation
- pend counter, width $clog2(MAX_PEND+1):
  - +1 on accepted id_set_flags.
  - −1 on ex_flag_valid.
  - Both in the same cycle: unchanged.
  - ex_flag_valid at pend==0: counter stays 0 and err sets.
- pend_next is the counter value after this edge.
- States: IDLE, WAIT, RESOLVE.
  - IDLE:
    - id_bcond_valid: capture id_cond and id_target. Go to RESOLVE if pend_next==0, else WAIT.
    - id_set_flags is accepted only when stall==0 and id_bcond_valid==0. If both inputs are high in one cycle, the branch wins, id_set_flags is ignored, and err sets.
  - WAIT: go to RESOLVE when pend_next==0.
  - RESOLVE: evaluate the held cond on flag_q, register br_valid=1, br_taken, and br_target, then return to IDLE.
- stall = (state != IDLE) | (pend == MAX_PEND).
- id_set_flags or id_bcond_valid while stall=1 is ignored and sets err.
- Condition evaluation (Z, N, V, C):
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 HS: C. 0011 LO: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !(C&!Z).
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: !GT.
  - 1110 and 1111: always taken.
- br_valid deasserts the cycle after it is raised. br_taken and br_target hold their values until the next resolution.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, pend=0, err=0.
  - br_valid=0, br_taken=0, br_target=0, stall=0.
  - Applies mid-operation too: a held branch is discarded and no pulse is emitted.
- Branch at cycle 0 with pend_next==0:
  - RESOLVE in cycle 1.
  - br_valid=1 in cycle 2, with state back in IDLE and stall=0.
- Branch waiting in WAIT, with the final ex_flag_valid in cycle k:
  - RESOLVE in cycle k+1, reading the flag register value updated at the edge ending cycle k.
  - br_valid in cycle k+2.
- Branch in IDLE in the same cycle as the final ex_flag_valid (pend 1→0): behaves like the pend_next==0 case.
- stall is combinational from state and pend, with no input-to-stall path.

## Configuration
- BCOND_FWD_EN defined:
  - In WAIT, when ex_flag_valid is high and pend==1, evaluate on ex_flags in that same cycle.
  - Register br_valid, go directly to IDLE, and skip RESOLVE.
  - Result: br_valid in cycle k+1.
- Not defined: always go through RESOLVE using flag_q (k+2 latency).
- Reset, error, and counter behaviour are identical in both builds.

## Test plan
- Reset, then B.cond EQ with pend=0 and flag_q=4'b1000 → cycle 2: br_valid=1, br_taken=1, br_target=id_target; stall=1 in cycle 1 only.
- id_set_flags, then B.cond GE issued the next cycle; ex_flags=4'b0110 arrives 2 cycles later → br_taken=1 (N==V). Pulse arrives one cycle earlier with BCOND_FWD_EN than without it.
- Three id_set_flags with MAX_PEND=3 → stall=1 while pend==3. One ex_flag_valid → stall=0 the next cycle.
- ex_flag_valid with pend=0 → err=1 and stays 1; pend stays 0.
- reset pulsed low while in WAIT → all outputs 0 immediately, and no br_valid follows.
- Sweep all 16 conditions against all 16 flag_q values at pend=0 → br_taken matches the condition table.
